// File: rtl/norm_shift_pipe.sv
// Pipelined leading-one normaliser: stage k tries a left shift of 2^(CNT_W-1-k), with valid/ready per stage.
// Define NORM_EXP_ADJ_EN to carry an exponent and produce out_exp / out_uflow.
module norm_shift_pipe #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5,
  parameter int TAG_W = 4,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
`ifdef NORM_EXP_ADJ_EN
  ,
  input  logic [EXP_W-1:0] in_exp,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_uflow
`endif
);

  localparam int LAST = CNT_W - 1;

  if (CNT_W != $clog2(WIDTH + 1) || WIDTH < 2 || WIDTH > 64 || EXP_W < 1) begin : g_badParams
    $error("norm_shift_pipe: illegal parameter combination");
  end

  logic             valid_q [CNT_W];
  logic [WIDTH-1:0] data_q  [CNT_W];
  logic [CNT_W-1:0] cnt_q   [CNT_W];
  logic             zero_q  [CNT_W];
  logic [TAG_W-1:0] tag_q   [CNT_W];
`ifdef NORM_EXP_ADJ_EN
  logic [EXP_W-1:0] exp_q   [CNT_W];
`endif

  logic [CNT_W:0] stageLoad;

  // A stage may load when it is empty or its successor is moving on, so bubbles collapse.
  always_comb begin
    stageLoad        = '0;
    stageLoad[CNT_W] = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      stageLoad[k] = !valid_q[k] || stageLoad[k+1];
    end
  end

  assign in_ready = stageLoad[0] || flush;

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    localparam int SHIFT = 1 << (LAST - k);
    localparam int TESTW = (SHIFT < WIDTH) ? SHIFT : WIDTH;

    logic             srcValid;
    logic             srcZero;
    logic             doShift;
    logic [WIDTH-1:0] srcData;
    logic [WIDTH-1:0] data_d;
    logic [CNT_W-1:0] srcCnt;
    logic [CNT_W-1:0] cnt_d;
    logic [TAG_W-1:0] srcTag;
`ifdef NORM_EXP_ADJ_EN
    logic [EXP_W-1:0] srcExp;
`endif

    if (k == 0) begin : g_head
      // A zero input starts with the full-width count; every shift is then suppressed.
      assign srcValid = in_valid;
      assign srcData  = in_data;
      assign srcZero  = (in_data == '0);
      assign srcCnt   = srcZero ? CNT_W'(WIDTH) : '0;
      assign srcTag   = in_tag;
`ifdef NORM_EXP_ADJ_EN
      assign srcExp   = in_exp;
`endif
    end else begin : g_body
      assign srcValid = valid_q[k-1];
      assign srcData  = data_q[k-1];
      assign srcZero  = zero_q[k-1];
      assign srcCnt   = cnt_q[k-1];
      assign srcTag   = tag_q[k-1];
`ifdef NORM_EXP_ADJ_EN
      assign srcExp   = exp_q[k-1];
`endif
    end

    assign doShift = !srcZero && (srcData[WIDTH-1 -: TESTW] == '0);
    assign data_d  = doShift ? (srcData << SHIFT) : srcData;
    assign cnt_d   = doShift ? (srcCnt | CNT_W'(SHIFT)) : srcCnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
        zero_q[k]  <= 1'b0;
        tag_q[k]   <= '0;
`ifdef NORM_EXP_ADJ_EN
        exp_q[k]   <= '0;
`endif
      end else if (flush) begin
        valid_q[k] <= 1'b0;
      end else if (stageLoad[k]) begin
        valid_q[k] <= srcValid;
        if (srcValid) begin
          data_q[k] <= data_d;
          cnt_q[k]  <= cnt_d;
          zero_q[k] <= srcZero;
          tag_q[k]  <= srcTag;
`ifdef NORM_EXP_ADJ_EN
          exp_q[k]  <= srcExp;
`endif
        end
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_cnt   = cnt_q[LAST];
  assign out_zero  = zero_q[LAST];
  assign out_tag   = tag_q[LAST];

`ifdef NORM_EXP_ADJ_EN
  localparam int MW = (EXP_W > CNT_W) ? EXP_W : CNT_W;

  // Exponent adjust sits after the last register; it only depends on held values, so it stays stable.
  assign out_exp   = exp_q[LAST] - EXP_W'(cnt_q[LAST]);
  assign out_uflow = zero_q[LAST] || (MW'(cnt_q[LAST]) > MW'(exp_q[LAST]));
`endif

endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: table vectors, hand sequences and random traffic checked against a leading-zero model.
// Define NORM_EXP_ADJ_EN to also exercise the exponent ports.
module tb_norm_shift_pipe;
  localparam int WIDTH = 24;
  localparam int CNT_W = 5;
  localparam int TAG_W = 4;
  localparam int EXP_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
`ifdef NORM_EXP_ADJ_EN
  logic [EXP_W-1:0] in_exp = '0;
  logic [EXP_W-1:0] out_exp;
  logic             out_uflow;
`endif

  norm_shift_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TAG_W(TAG_W), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
`ifdef NORM_EXP_ADJ_EN
    ,
    .in_exp    (in_exp),
    .out_exp   (out_exp),
    .out_uflow (out_uflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    bit               zero;
    logic [TAG_W-1:0] tag;
    logic [EXP_W-1:0] exp;
    bit               uflow;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] expData;
    int               expCnt;
    bit               expZero;
  } vec_t;

  res_t modelQ[$];
  int   drainCycles[$];
  vec_t tbl [8];
  int   vecCount = 0;
  int   missCount = 0;
  int   cyc = 0;

  // Reference: count leading zeros by plain bit walking; a zero input reports the full width.
  function automatic void refNorm(input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] nd,
                                  output int c, output bit z);
    z  = (d == '0);
    nd = d;
    c  = 0;
    if (z) begin
      c = WIDTH;
      return;
    end
    while (nd[WIDTH-1] == 1'b0) begin
      nd = nd << 1;
      c++;
    end
  endfunction

  function automatic logic [WIDTH-1:0] randData();
    logic [WIDTH-1:0] d;
    d = WIDTH'($urandom());
    return d >> $urandom_range(0, WIDTH);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of inputs, score any drain against the model, record any accept, then step the clock.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t,
                               input logic [EXP_W-1:0] e, input bit rdy, input bit fl);
    res_t             r;
    logic [WIDTH-1:0] nd;
    int               c;
    bit               z;
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = rdy;
    flush     = fl;
`ifdef NORM_EXP_ADJ_EN
    in_exp    = e;
`endif
    #1;
    if (modelQ.size() == 0) begin
      checkOutput("noStaleValid", out_valid, 0);
    end else if (out_valid && out_ready) begin
      r = modelQ.pop_front();
      checkOutput("sbData", out_data, r.data);
      checkOutput("sbCnt", out_cnt, r.cnt);
      checkOutput("sbZero", out_zero, r.zero);
      checkOutput("sbTag", out_tag, r.tag);
`ifdef NORM_EXP_ADJ_EN
      checkOutput("sbExp", out_exp, r.exp);
      checkOutput("sbUflow", out_uflow, r.uflow);
`endif
      drainCycles.push_back(cyc);
    end
    if (v && in_ready && !fl) begin
      refNorm(d, nd, c, z);
      r.data  = nd;
      r.cnt   = CNT_W'(c);
      r.zero  = z;
      r.tag   = t;
      r.exp   = e - EXP_W'(c);
      r.uflow = z || (c > int'(e));
      modelQ.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fl) modelQ.delete();
  endtask

  task automatic runSingle(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t,
                           input logic [EXP_W-1:0] e, output int lat);
    applyStimulus(1'b1, d, t, e, 1'b1, 1'b0);
    lat = 1;
    while (!out_valid && lat < 4 * CNT_W) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int mark;

    tbl[0] = '{24'h000001, 4'h3, 24'h800000, 23, 1'b0};
    tbl[1] = '{24'h000000, 4'h5, 24'h000000, 24, 1'b1};
    tbl[2] = '{24'h800000, 4'h1, 24'h800000, 0,  1'b0};
    tbl[3] = '{24'h400000, 4'h2, 24'h800000, 1,  1'b0};
    tbl[4] = '{24'h00ABCD, 4'h7, 24'hABCD00, 8,  1'b0};
    tbl[5] = '{24'h000003, 4'hA, 24'hC00000, 22, 1'b0};
    tbl[6] = '{24'hFFFFFF, 4'hF, 24'hFFFFFF, 0,  1'b0};
    tbl[7] = '{24'h012345, 4'h9, 24'h91A280, 7,  1'b0};

    #12;
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutData", out_data, 0);
    checkOutput("rstOutCnt", out_cnt, 0);
    checkOutput("rstOutZero", out_zero, 0);
    checkOutput("rstOutTag", out_tag, 0);
    checkOutput("rstInReady", in_ready, 1);
`ifdef NORM_EXP_ADJ_EN
    checkOutput("rstOutExp", out_exp, 0);
    checkOutput("rstOutUflow", out_uflow, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postRstInReady", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      runSingle(tbl[i].data, tbl[i].tag, EXP_W'(30), lat);
      checkOutput("tblLatency", lat, CNT_W);
      checkOutput("tblData", out_data, tbl[i].expData);
      checkOutput("tblCnt", out_cnt, tbl[i].expCnt);
      checkOutput("tblZero", out_zero, tbl[i].expZero);
      checkOutput("tblTag", out_tag, tbl[i].tag);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end

    $display("[TB] back-to-back stream");
    drainCycles.delete();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, randData(), TAG_W'(i), EXP_W'($urandom()), 1'b1, 1'b0);
    end
    for (int i = 0; i < 40 && modelQ.size() != 0; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    checkOutput("streamCount", drainCycles.size(), 32);
    if (drainCycles.size() == 32) begin
      checkOutput("streamSpan", drainCycles[31] - drainCycles[0], 31);
    end

    $display("[TB] backpressure hold");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, randData(), TAG_W'(i + 3), EXP_W'($urandom()), 1'b0, 1'b0);
      if (i > 4) begin
        checkOutput("holdValid", out_valid, 1);
        checkOutput("holdData", out_data, modelQ[0].data);
        checkOutput("holdTag", out_tag, modelQ[0].tag);
      end
    end
    checkOutput("fullInReady", in_ready, 0);
    checkOutput("fullCount", modelQ.size(), CNT_W);
    out_ready = 1'b1;
    #1;
    checkOutput("fullSimulReady", in_ready, 1);
    applyStimulus(1'b1, randData(), 4'hC, EXP_W'($urandom()), 1'b1, 1'b0);
    checkOutput("fullCountAfterSwap", modelQ.size(), CNT_W);
    for (int i = 0; i < 30 && modelQ.size() != 0; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    checkOutput("holdDrained", modelQ.size(), 0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, randData(), TAG_W'(i + 1), EXP_W'($urandom()), 1'b1, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstOutData", out_data, 0);
    checkOutput("midRstOutTag", out_tag, 0);
    modelQ.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRstInReady", in_ready, 1);
    mark = drainCycles.size();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("midRstNoItems", drainCycles.size() - mark, 0);

    $display("[TB] flush");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, randData(), TAG_W'(i + 8), EXP_W'($urandom()), 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 24'h000010, 4'h2, '0, 1'b1, 1'b1);
    checkOutput("flushOutValid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, randData(), TAG_W'(i), EXP_W'($urandom()), 1'b0, 1'b0);
    end
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    checkOutput("flushInReadyFull", in_ready, 1);
    applyStimulus(1'b1, 24'h000020, 4'h4, '0, 1'b0, 1'b1);
    checkOutput("flushFullOutValid", out_valid, 0);
    mark = drainCycles.size();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("flushNoItems", drainCycles.size() - mark, 0);

`ifdef NORM_EXP_ADJ_EN
    $display("[TB] exponent adjust");
    runSingle(24'h000100, 4'h6, 10'd20, lat);
    checkOutput("expCnt", out_cnt, 15);
    checkOutput("expVal", out_exp, 10'd5);
    checkOutput("expUflow", out_uflow, 0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    runSingle(24'h000100, 4'h6, 10'd10, lat);
    checkOutput("expWrap", out_exp, 10'h3FB);
    checkOutput("expWrapUflow", out_uflow, 1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    runSingle(24'h000000, 4'h1, 10'd100, lat);
    checkOutput("expZeroUflow", out_uflow, 1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randData(), TAG_W'($urandom()), EXP_W'($urandom()),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end
    for (int i = 0; i < 50 && modelQ.size() != 0; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    checkOutput("finalDrain", modelQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
